// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the execute-stage branch resolver.
// FSM encodings and PC step constant.
package branch_resolver_pkg;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] ZERO    = 32'd0;

endpackage

// File: rtl/branch_cond_unit.sv
// Combinational branch condition evaluation.
// Maps the one-hot branch class and operands to the taken outcome.
module branch_cond_unit (
  input  logic        B_type_ex,
  input  logic        beq_ex,
  input  logic        bne_ex,
  input  logic        blt_ex,
  input  logic        bge_ex,
  input  logic        bltu_ex,
  input  logic        bgeu_ex,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        taken
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (rs1_data == rs2_data);
  assign lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign ltu = (rs1_data < rs2_data);

  assign taken = B_type_ex & (
      (beq_ex  &  eq ) |
      (bne_ex  & ~eq ) |
      (blt_ex  &  lt ) |
      (bge_ex  & ~lt ) |
      (bltu_ex &  ltu) |
      (bgeu_ex & ~ltu));

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: mispredict detection, flush
// pulse, redirect, predictor rollback bundle and perf counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PL_stall,
  input  logic                 B_type_ex,
  input  logic                 beq_ex,
  input  logic                 bne_ex,
  input  logic                 blt_ex,
  input  logic                 bge_ex,
  input  logic                 bltu_ex,
  input  logic                 bgeu_ex,
  input  logic                 jalr_ex,
  input  logic                 jalr_pred_used_ex,
  input  logic [31:0]          pc_ex,
  input  logic [31:0]          imme_ex,
  input  logic [31:0]          rs1_data,
  input  logic [31:0]          rs2_data,
  input  logic                 prediction_result_ex,
  input  logic [31:0]          jalr_pc_pred_ex,
  output logic                 corrected_result,
  output logic                 PL_flush,
  output logic [31:0]          redirect_pc,
  output logic                 B_type_branch_failed,
  output logic                 beq_branch_failed,
  output logic                 bne_branch_failed,
  output logic                 blt_branch_failed,
  output logic                 bge_branch_failed,
  output logic                 bltu_branch_failed,
  output logic                 bgeu_branch_failed,
  output logic [31:0]          pc_branch_failed,
  output logic                 prediction_result_branch_failed,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] branch_miss_cnt,
  output logic [CNT_WIDTH-1:0] jalr_miss_cnt
);

  br_state_t   state;
  logic        b_miss;
  logic        j_miss;
  logic [31:0] jalr_target;
  logic [31:0] b_redirect;

  branch_cond_unit u_cond (
    .B_type_ex (B_type_ex),
    .beq_ex    (beq_ex),
    .bne_ex    (bne_ex),
    .blt_ex    (blt_ex),
    .bge_ex    (bge_ex),
    .bltu_ex   (bltu_ex),
    .bgeu_ex   (bgeu_ex),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .taken     (corrected_result)
  );

  assign jalr_target = (rs1_data + imme_ex) & ~32'd1;
  assign b_redirect  = corrected_result ? (pc_ex + imme_ex)
                                        : (pc_ex + PC_STEP);
  assign b_miss = B_type_ex &
                  (corrected_result != prediction_result_ex);
  assign j_miss = jalr_ex & (~jalr_pred_used_ex |
                  (jalr_target != jalr_pc_pred_ex));

  always_ff @(posedge clk) begin
    if (rst) begin
      state                           <= BR_IDLE;
      PL_flush                        <= 1'b0;
      redirect_pc                     <= ZERO;
      B_type_branch_failed            <= 1'b0;
      beq_branch_failed               <= 1'b0;
      bne_branch_failed               <= 1'b0;
      blt_branch_failed               <= 1'b0;
      bge_branch_failed               <= 1'b0;
      bltu_branch_failed              <= 1'b0;
      bgeu_branch_failed              <= 1'b0;
      pc_branch_failed                <= ZERO;
      prediction_result_branch_failed <= 1'b0;
      branch_cnt                      <= '0;
      branch_miss_cnt                 <= '0;
      jalr_miss_cnt                   <= '0;
    end else begin
      unique case (state)
        BR_IDLE: begin
          PL_flush <= 1'b0;
          if (!PL_stall) begin
            if (B_type_ex)
              branch_cnt <= branch_cnt + 1'b1;
            if (b_miss)
              branch_miss_cnt <= branch_miss_cnt + 1'b1;
            if (j_miss)
              jalr_miss_cnt <= jalr_miss_cnt + 1'b1;
            if (b_miss || j_miss) begin
              state       <= BR_FLUSH;
              PL_flush    <= 1'b1;
              redirect_pc <= b_miss ? b_redirect : jalr_target;
              B_type_branch_failed            <= B_type_ex;
              beq_branch_failed               <= beq_ex;
              bne_branch_failed               <= bne_ex;
              blt_branch_failed               <= blt_ex;
              bge_branch_failed               <= bge_ex;
              bltu_branch_failed              <= bltu_ex;
              bgeu_branch_failed              <= bgeu_ex;
              pc_branch_failed                <= pc_ex;
              prediction_result_branch_failed <= prediction_result_ex;
            end
          end
        end
        // EX holds a wrong-path instruction; leave regardless of stall
        BR_FLUSH: begin
          PL_flush <= 1'b0;
          state    <= BR_IDLE;
        end
        default: begin
          PL_flush <= 1'b0;
          state    <= BR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed cases then
// random traffic against a behavioural model.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        PL_stall;
  logic        B_type_ex, beq_ex, bne_ex, blt_ex;
  logic        bge_ex, bltu_ex, bgeu_ex;
  logic        jalr_ex, jalr_pred_used_ex;
  logic [31:0] pc_ex, imme_ex, rs1_data, rs2_data;
  logic        prediction_result_ex;
  logic [31:0] jalr_pc_pred_ex;
  logic        corrected_result, PL_flush;
  logic [31:0] redirect_pc, pc_branch_failed;
  logic        B_type_branch_failed, beq_branch_failed;
  logic        bne_branch_failed, blt_branch_failed;
  logic        bge_branch_failed, bltu_branch_failed;
  logic        bgeu_branch_failed;
  logic        prediction_result_branch_failed;
  logic [31:0] branch_cnt, branch_miss_cnt, jalr_miss_cnt;

  branch_resolver #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .PL_stall(PL_stall),
    .B_type_ex(B_type_ex), .beq_ex(beq_ex), .bne_ex(bne_ex),
    .blt_ex(blt_ex), .bge_ex(bge_ex), .bltu_ex(bltu_ex),
    .bgeu_ex(bgeu_ex), .jalr_ex(jalr_ex),
    .jalr_pred_used_ex(jalr_pred_used_ex),
    .pc_ex(pc_ex), .imme_ex(imme_ex),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .prediction_result_ex(prediction_result_ex),
    .jalr_pc_pred_ex(jalr_pc_pred_ex),
    .corrected_result(corrected_result),
    .PL_flush(PL_flush), .redirect_pc(redirect_pc),
    .B_type_branch_failed(B_type_branch_failed),
    .beq_branch_failed(beq_branch_failed),
    .bne_branch_failed(bne_branch_failed),
    .blt_branch_failed(blt_branch_failed),
    .bge_branch_failed(bge_branch_failed),
    .bltu_branch_failed(bltu_branch_failed),
    .bgeu_branch_failed(bgeu_branch_failed),
    .pc_branch_failed(pc_branch_failed),
    .prediction_result_branch_failed(prediction_result_branch_failed),
    .branch_cnt(branch_cnt),
    .branch_miss_cnt(branch_miss_cnt),
    .jalr_miss_cnt(jalr_miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic [31:0] redirect;
    logic [6:0]  cls;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] bc;
    logic [31:0] bmc;
    logic [31:0] jmc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  // model state
  bit   m_in_flush;
  exp_t m;

  function automatic bit cond_of(int kind, logic [31:0] a,
                                 logic [31:0] b);
    case (kind)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) <  $signed(b);
      3: return $signed(a) >= $signed(b);
      4: return a <  b;
      5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  int cur_kind;

  task automatic set_ex(int kind, logic [31:0] a, logic [31:0] b,
                        logic [31:0] pc, logic [31:0] imm,
                        logic pred, logic used, logic [31:0] jp);
    cur_kind  = kind;
    B_type_ex = (kind < 6);
    beq_ex    = (kind == 0);
    bne_ex    = (kind == 1);
    blt_ex    = (kind == 2);
    bge_ex    = (kind == 3);
    bltu_ex   = (kind == 4);
    bgeu_ex   = (kind == 5);
    jalr_ex   = (kind == 6);
    rs1_data  = a;
    rs2_data  = b;
    pc_ex     = pc;
    imme_ex   = imm;
    prediction_result_ex = pred;
    jalr_pred_used_ex    = used;
    jalr_pc_pred_ex      = jp;
  endtask

  // apply current inputs for one cycle; model the edge; push expectation
  task automatic step();
    bit          tk, bm, jm;
    logic [31:0] tgt;
    #1;
    tk = (cur_kind < 6) && cond_of(cur_kind, rs1_data, rs2_data);
    n_checks++;
    if (corrected_result !== tk) begin
      n_fail++;
      $display("FAIL corrected_result kind=%0d got=%b want=%b",
               cur_kind, corrected_result, tk);
    end
    tgt = (rs1_data + imme_ex) & 32'hFFFF_FFFE;
    bm  = (cur_kind < 6) && (tk != prediction_result_ex);
    jm  = (cur_kind == 6) &&
          (!jalr_pred_used_ex || tgt != jalr_pc_pred_ex);
    m.flush = 1'b0;
    if (rst) begin
      m = '0;
      m_in_flush = 0;
    end else if (m_in_flush) begin
      m_in_flush = 0;
    end else if (!PL_stall) begin
      if (cur_kind < 6) m.bc = m.bc + 1;
      if (bm) m.bmc = m.bmc + 1;
      if (jm) m.jmc = m.jmc + 1;
      if (bm || jm) begin
        m_in_flush = 1;
        m.flush    = 1'b1;
        m.redirect = bm ? (tk ? pc_ex + imme_ex : pc_ex + 32'd4)
                        : tgt;
        m.cls  = {B_type_ex, beq_ex, bne_ex, blt_ex,
                  bge_ex, bltu_ex, bgeu_ex};
        m.pc   = pc_ex;
        m.pred = prediction_result_ex;
      end
    end
    exp_q.push_back(m);
    @(negedge clk);
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // monitor: compare registered outputs after every edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("PL_flush", 32'(PL_flush), 32'(e.flush));
        chk("redirect_pc", redirect_pc, e.redirect);
        chk("failed_class", 32'({B_type_branch_failed,
            beq_branch_failed, bne_branch_failed, blt_branch_failed,
            bge_branch_failed, bltu_branch_failed,
            bgeu_branch_failed}), 32'(e.cls));
        chk("pc_branch_failed", pc_branch_failed, e.pc);
        chk("pred_failed", 32'(prediction_result_branch_failed),
            32'(e.pred));
        chk("branch_cnt", branch_cnt, e.bc);
        chk("branch_miss_cnt", branch_miss_cnt, e.bmc);
        chk("jalr_miss_cnt", jalr_miss_cnt, e.jmc);
      end
    end
  end

  initial begin
    int k;
    logic [31:0] a, b, t;
    m = '0;
    m_in_flush = 0;
    rst = 1'b1;
    PL_stall = 1'b0;
    set_ex(7, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    // bge -5 >= 3 is false, predicted taken
    set_ex(3, 32'hFFFF_FFFB, 32'd3, 32'h40, 32'h20, 1, 0, 0);
    step();
    set_ex(7, 0, 0, 0, 0, 0, 0, 0);
    step();
    // bltu 1 < 0xFFFFFFFF taken, predicted taken
    set_ex(4, 32'd1, 32'hFFFF_FFFF, 32'h100, 32'h10, 1, 0, 0);
    step();
    // jalr correct then wrong target
    set_ex(6, 32'h2001, 0, 32'h200, 0, 0, 1, 32'h2000);
    step();
    set_ex(6, 32'h2001, 0, 32'h200, 0, 0, 1, 32'h3000);
    step();
    set_ex(7, 0, 0, 0, 0, 0, 0, 0);
    step();
    // two consecutive mispredicts: second is wrong-path
    set_ex(0, 5, 5, 32'h300, 32'h40, 0, 0, 0);
    step();
    set_ex(1, 5, 5, 32'h304, 32'h40, 1, 0, 0);
    step();
    // back-to-back after flush is evaluated
    step();
    set_ex(7, 0, 0, 0, 0, 0, 0, 0);
    step();
    // stall held 3 cycles over a mispredict
    PL_stall = 1'b1;
    set_ex(2, 32'hFFFF_FFFF, 1, 32'h500, 32'h80, 0, 0, 0);
    step(); step(); step();
    PL_stall = 1'b0;
    step();
    // stall during FLUSH does not extend pulse
    PL_stall = 1'b1;
    step();
    set_ex(7, 0, 0, 0, 0, 0, 0, 0);
    step();
    PL_stall = 1'b0;
    // reset during the FLUSH cycle
    set_ex(5, 0, 1, 32'h600, 32'h8, 1, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    // redirect wraps past 2^32
    set_ex(0, 7, 7, 32'hFFFF_FFFC, 32'd8, 0, 0, 0);
    step();
    set_ex(7, 0, 0, 0, 0, 0, 0, 0);
    step();
    // random traffic
    for (int i = 0; i < 800; i++) begin
      k = int'($urandom_range(0, 8));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a + 32'd1;
      t = (a + 32'h10) & 32'hFFFF_FFFE;
      if ($urandom_range(0, 1) == 1) t = $urandom;
      set_ex(k > 6 ? 7 : k, a, b, $urandom, 32'h10,
             1'($urandom), 1'($urandom_range(0, 4) != 0), t);
      if (k == 6) imme_ex = 32'h10;
      else imme_ex = $urandom;
      PL_stall = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;
    PL_stall = 1'b0;
    set_ex(7, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
